memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 32: max cycles in ACCESS awaiting synchronized mfc before aborting.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0/req1  input  1  access request, port 0 / port 1; held until ack.
REQ-005 rw0/rw1  input  1  1 = read, 0 = write.
REQ-006 addr0/addr1  input  16  word address.
REQ-007 wdata0/wdata1  input  16  write data.
REQ-008 ack0/ack1  output  1  one-cycle completion pulse.
REQ-009 err0/err1  output  1  one-cycle timeout flag, coincident with ack.
REQ-010 rdata0/rdata1  output  16  read data, per port, held until that port's next successful read.
REQ-011 enable  output  1  memory access strobe.
REQ-012 rw  output  1  memory direction, 1 = read, 0 = write.
REQ-013 address  output  16  memory address.
REQ-014 memoryOut  output  16  data to memory.
REQ-015 memoryIn  input  16  data from memory; may be high-Z outside reads.
REQ-016 mfc  input  1  memory function complete, asynchronous level.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 grant  output  1  port owning the current or last access.

Function
REQ-019 mfc SHALL pass through a two-flop synchronizer (mfc_s) before any use.
REQ-020 States SHALL be IDLE, ACCESS and RELEASE.
REQ-021 IDLE, any req high: latch port id, rw, address and wdata into output registers; go to ACCESS; enable high from the next cycle.
REQ-022 Both req high in IDLE: grant the port not granted last; the last-grant register resets to 1, so port 0 wins the first tie.
REQ-023 ACCESS: enable=1, rw/address held constant; memoryOut = latched wdata on writes, 0x0000 on reads.
REQ-024 ACCESS with mfc_s=1: on a read, capture memoryIn into rdata of the granted port; pulse that port's ack for the next cycle; set enable=0; go to RELEASE.
REQ-025 ACCESS lasting TIMEOUT cycles without mfc_s: pulse ack and err of the granted port; leave rdata unchanged; set enable=0; go to RELEASE.
REQ-026 RELEASE: remain until mfc_s=0, or for at most TIMEOUT cycles, then go to IDLE; no new access starts while mfc_s=1.
REQ-027 Latency: req sampled at edge N gives enable high in cycle N+1; ack is high in the cycle after the edge where mfc_s is first seen high.
REQ-028 req dropped before ack: the access still completes and ack still pulses.
REQ-029 req still high when IDLE is re-entered is treated as a new request.
REQ-030 Only the granted port's ack/err/rdata change; the other port's outputs are untouched.
REQ-031 The ACCESS cycle counter SHALL saturate and clear on every state entry.

Reset
REQ-032 When rst=1 at a posedge: state=IDLE; enable=0, rw=0, address=0, memoryOut=0, ack0/1=0, err0/1=0, rdata0/1=0, busy=0, grant=0, last-grant=1, synchronizer and counter cleared.
REQ-033 rst asserted mid-ACCESS or mid-RELEASE: the access is abandoned; enable=0 after that edge; no ack or err is issued.

Verification
REQ-034 Port0 read, addr 0x0003, memory returns 0x9044, mfc rises 5 cycles after enable -> rw=1, address=0x0003; ack0 pulses one cycle with rdata0=0x9044, err0=0; ack1 stays 0.
REQ-035 Port1 write, addr 0x00C3, data 0xBEEF -> rw=0, memoryOut=0xBEEF while enable=1; ack1 pulses; rdata1 unchanged.
REQ-036 req0 and req1 high together after reset, held through two accesses -> port0 served first, then port1; a second simultaneous pair starts with port0 again (alternation).
REQ-037 mfc held 0 -> after exactly 32 ACCESS cycles, ack0 and err0 pulse together, enable drops, rdata0 unchanged, return to IDLE.
REQ-038 rst pulsed 3 cycles into ACCESS -> enable=0 next edge, no ack; a following port1 read completes normally.
REQ-039 mfc held high 10 cycles after completion with req1 pending -> enable does not rise until 2 cycles after mfc falls.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two requesting ports, the arbiter and the memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface memory_arbiter_if;
  logic        req0;
  logic        req1;
  logic        rw0;
  logic        rw1;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic        err0;
  logic        err1;
  logic [15:0] rdata0;
  logic [15:0] rdata1;
  logic        enable;
  logic        rw;
  logic [15:0] address;
  logic [15:0] memoryOut;
  logic [15:0] memoryIn;
  logic        mfc;
  logic        busy;
  logic        grant;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, memoryIn, mfc,
    output ack0, ack1, err0, err1, rdata0, rdata1,
    output enable, rw, address, memoryOut, busy, grant
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, memoryIn, mfc,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
    input  enable, rw, address, memoryOut, busy, grant
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port arbiter in front of a single asynchronous-handshake memory.
// Alternating tie-break, timeout on a missing mfc, all outputs registered.
module memory_arbiter #(
  parameter int TIMEOUT = 32
) (
  input logic              clk,
  input logic              rst,
  memory_arbiter_if.slave  bus
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          grant;
    logic          enable;
    logic          rw;
    logic [15:0]   address;
    logic [15:0]   mem_out;
    logic          ack0;
    logic          ack1;
    logic          err0;
    logic          err1;
    logic [15:0]   rdata0;
    logic [15:0]   rdata1;
  } regs_t;

  regs_t r;
  regs_t n;
  logic  mfc_meta;
  logic  mfc_s;
  logic  grant_sel;

  // mfc comes from the memory's own timing domain; only mfc_s is ever used.
  always_ff @(posedge clk) begin
    if (rst) begin
      mfc_meta <= 1'b0;
      mfc_s    <= 1'b0;
    end else begin
      mfc_meta <= bus.mfc;
      mfc_s    <= mfc_meta;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r            <= '0;
      r.state      <= IDLE;
      r.last_grant <= 1'b1;
    end else begin
      r <= n;
    end
  end

  // NOTE: every field of n starts from the current register value (and the
  // pulses from 0) before any branch, so no path can infer a latch.
  always_comb begin
    n         = r;
    n.ack0    = 1'b0;
    n.ack1    = 1'b0;
    n.err0    = 1'b0;
    n.err1    = 1'b0;
    grant_sel = (bus.req0 && bus.req1) ? ~r.last_grant : bus.req1;

    unique case (r.state)
      IDLE: begin
        if ((bus.req0 || bus.req1) && !mfc_s) begin
          n.state      = ACCESS;
          n.cnt        = '0;
          n.grant      = grant_sel;
          n.last_grant = grant_sel;
          n.enable     = 1'b1;
          n.rw         = grant_sel ? bus.rw1   : bus.rw0;
          n.address    = grant_sel ? bus.addr1 : bus.addr0;
          n.mem_out    = (grant_sel ? bus.rw1 : bus.rw0) ? 16'h0000
                       : (grant_sel ? bus.wdata1 : bus.wdata0);
        end
      end

      ACCESS: begin
        if (mfc_s) begin
          n.state  = RELEASE;
          n.cnt    = '0;
          n.enable = 1'b0;
          if (r.grant) n.ack1 = 1'b1;
          else         n.ack0 = 1'b1;
          if (r.rw) begin
            if (r.grant) n.rdata1 = bus.memoryIn;
            else         n.rdata0 = bus.memoryIn;
          end
        end else if (r.cnt == CNT_LAST) begin
          // Timeout: complete with an error, read data left untouched.
          n.state  = RELEASE;
          n.cnt    = '0;
          n.enable = 1'b0;
          if (r.grant) begin
            n.ack1 = 1'b1;
            n.err1 = 1'b1;
          end else begin
            n.ack0 = 1'b1;
            n.err0 = 1'b1;
          end
        end else begin
          n.cnt = r.cnt + 1'b1;
        end
      end

      RELEASE: begin
        // Wait for the memory to drop mfc, but never forever.
        if (!mfc_s || r.cnt == CNT_LAST) begin
          n.state = IDLE;
          n.cnt   = '0;
        end else begin
          n.cnt = r.cnt + 1'b1;
        end
      end

      default: begin
        n.state  = IDLE;
        n.cnt    = '0;
        n.enable = 1'b0;
      end
    endcase
  end

  assign bus.ack0      = r.ack0;
  assign bus.ack1      = r.ack1;
  assign bus.err0      = r.err0;
  assign bus.err1      = r.err1;
  assign bus.rdata0    = r.rdata0;
  assign bus.rdata1    = r.rdata1;
  assign bus.enable    = r.enable;
  assign bus.rw        = r.rw;
  assign bus.address   = r.address;
  assign bus.memoryOut = r.mem_out;
  assign bus.grant     = r.grant;
  assign bus.busy      = (r.state != IDLE);

endmodule
